eth_deframer: RTL and testbench
===============================

Name: eth_deframer

Overview:
- Receive-side counterpart of eth_framer. Sits between the rmii_to_axis RX stream and the payload consumer.
- Parses the Ethernet header, captures destination MAC, source MAC and ethertype, and filters on destination MAC.
- Strips the 4-byte FCS, checks CRC-32, frame length and PHY errors.
- Emits the payload as a byte AXIS stream whose last beat carries an error flag, so a downstream packet FIFO can drop bad frames.

Parameters:
- PROMISCUOUS, 0, 1 = accept any destination MAC.
- ACCEPT_BROADCAST, 1, 1 = accept destination FF:FF:FF:FF:FF:FF.
- CHECK_FCS, 1, 1 = a CRC mismatch sets the error flag; 0 = CRC ignored.
- MIN_FRAME, 64, minimum legal frame bytes (header+payload+FCS).
- MAX_FRAME, 1518, maximum legal frame bytes.

Ports:
- clk  in  1  clock
- sreset  in  1  synchronous reset, active high
- local_mac  in  48  station MAC, MSB = first byte on wire
- in_axis_tvalid  in  1  RX byte valid (no tready; source cannot stall)
- in_axis_tlast  in  1  last byte of frame (final FCS byte)
- in_axis_tdata  in  8  RX byte; first byte = dst MAC MSB (preamble/SFD already removed)
- in_axis_tuser  in  1  PHY error on this beat
- out_axis_tvalid  out  1  payload byte valid (no tready)
- out_axis_tlast  out  1  last payload byte
- out_axis_tdata  out  8  payload byte
- out_axis_tuser  out  1  on tlast beat: frame bad
- dst_mac  out  48  captured destination MAC
- src_mac  out  48  captured source MAC
- ethertype  out  16  captured ethertype
- hdr_valid  out  1  one-cycle pulse: header captured, frame accepted
- frame_ok  out  1  one-cycle pulse: accepted frame ended good
- frame_err  out  1  one-cycle pulse: accepted frame ended bad

Behaviour:
- Reset values: all outputs 0, byte counter 0, CRC register 32'hFFFFFFFF, state RESYNC.
- States and transitions:
  - RESYNC: discard beats until a beat with tlast, then go to HDR. Any frame in progress at reset is never output.
  - HDR: bytes 0-5 shift into dst_mac, 6-11 into src_mac, 12-13 into ethertype, all MSB first.
  - Filter decision on byte 5. Accept if PROMISCUOUS, or dst==local_mac, or (ACCEPT_BROADCAST and dst all-ones); otherwise go to DROP.
  - On byte 13 of an accepted frame: hdr_valid pulses the following cycle, then go to PAYLOAD. Captured fields hold until the next accepted header.
  - PAYLOAD: every byte enters a 4-deep delay line. Once 4 bytes are held, each new beat pushes out the oldest byte as an out beat. out_axis_tlast = in_axis_tlast of that input beat. The 4 bytes left in the line are the FCS and are never output.
  - DROP: discard until tlast, then HDR. No outputs, no pulses.
- Latency: an out beat is registered one cycle after the input beat that pushed it out. First payload byte appears after input byte 18 (0-based).
- CRC:
  - Reflected CRC-32, poly 32'hEDB88320, init all-ones, one byte per beat, computed over all bytes from dst MAC through the FCS.
  - Good frame when the register equals 32'hDEBB20E3 after the tlast byte.
  - CRC resets to all-ones at each frame start.
- Byte counter: 11-bit, saturating at 2047; counts every beat of the frame.
- Error flag (sticky per frame) is set by any of:
  - in_axis_tuser on any beat;
  - CRC bad with CHECK_FCS=1;
  - count < MIN_FRAME at tlast;
  - count > MAX_FRAME.
- Frame end: out_axis_tuser = error flag on the tlast out beat, 0 on all other beats. frame_ok or frame_err pulses in the same cycle as the tlast out beat.
- Short frames: tlast at total length ≤ 18 in HDR or PAYLOAD produces no out beats. If the header was accepted, frame_err pulses; state returns to HDR. A tlast in HDR before byte 5 counts as a runt with no pulses.
- Input gaps: tvalid low has no effect; state and delay line hold.
- Back-to-back frames: a tlast beat followed next cycle by a tvalid beat starts the new header with no gap required.
- Reset mid-frame: all state cleared, outputs 0 next cycle, then RESYNC.

Test Plan:
- Reset, send 1 dummy frame, then a frame with dst FF..FF, src 000102030405, type 88B5, 46 payload bytes 00..2D, valid FCS → hdr_valid once; src_mac=000102030405, ethertype=88B5; 46 out beats 00..2D; tlast on 2D with tuser=0; frame_ok pulse.
- Same frame, payload byte 10 flipped to FF → 46 out beats; tuser=1 on last; frame_err pulse; CHECK_FCS=0 build → tuser=0, frame_ok.
- local_mac=000102030405, dst=0A0B0C0D0E0F, PROMISCUOUS=0 → no out beats, no hdr_valid, no pulses. PROMISCUOUS=1 → frame passes.
- 16-byte frame (14 header + 2) → no out beats, hdr_valid once, frame_err pulse. 60-byte frame with valid FCS → 42 out beats, tuser=1 (runt).
- in_axis_tuser=1 on byte 30 of a 64-byte valid frame → 46 out beats, tuser=1 on last, frame_err.
- Random tvalid gaps plus back-to-back frames → output data identical to the gap-free case. Assert sreset at byte 20 → outputs 0; rest of that frame discarded until tlast; next good frame → frame_ok.

Source files
------------

// File: rtl/eth_deframer.sv
// Receive-side Ethernet deframer: header capture, destination MAC filtering,
// FCS stripping, CRC-32/length/PHY-error checking, payload out as byte AXIS.
module eth_deframer #(
    parameter bit PROMISCUOUS      = 1'b0,
    parameter bit ACCEPT_BROADCAST = 1'b1,
    parameter bit CHECK_FCS        = 1'b1,
    parameter int MIN_FRAME        = 64,
    parameter int MAX_FRAME        = 1518
) (
    input  logic        clk,
    input  logic        sreset,
    input  logic [47:0] local_mac,
    input  logic        in_axis_tvalid,
    input  logic        in_axis_tlast,
    input  logic [7:0]  in_axis_tdata,
    input  logic        in_axis_tuser,
    output logic        out_axis_tvalid,
    output logic        out_axis_tlast,
    output logic [7:0]  out_axis_tdata,
    output logic        out_axis_tuser,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic        frame_ok,
    output logic        frame_err
);

    localparam logic [1:0] ST_RESYNC  = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    localparam logic [10:0] MIN_L     = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_L     = 11'(MAX_FRAME);
    localparam logic [31:0] CRC_RESID = 32'hDEBB20E3;

    logic [1:0]  state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        err_q, err_d;
    logic [47:0] dst_sh_q, dst_sh_d;
    logic [47:0] src_sh_q, src_sh_d;
    logic [15:0] et_sh_q, et_sh_d;
    logic [31:0] dly_q, dly_d;
    logic [2:0]  fill_q, fill_d;

    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_user_q, out_user_d;
    logic [47:0] dst_mac_q, dst_mac_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [15:0] ethertype_q, ethertype_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;

    logic [10:0] cnt_inc;
    logic [31:0] crc_nx;
    logic        err_nx;
    logic [47:0] dst_full;
    logic        accept_now;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        cnt_inc    = (cnt_q == 11'd2047) ? cnt_q : cnt_q + 11'd1;
        crc_nx     = crc_byte(crc_q, in_axis_tdata);
        // Error status as it stands once the current beat is included.
        err_nx     = err_q | in_axis_tuser | (cnt_inc > MAX_L)
                   | (in_axis_tlast & (cnt_inc < MIN_L))
                   | (CHECK_FCS & in_axis_tlast & (crc_nx != CRC_RESID));
        dst_full   = {dst_sh_q[39:0], in_axis_tdata};
        accept_now = PROMISCUOUS || (dst_full == local_mac)
                   || (ACCEPT_BROADCAST && (&dst_full));

        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        err_d       = err_q;
        dst_sh_d    = dst_sh_q;
        src_sh_d    = src_sh_q;
        et_sh_d     = et_sh_q;
        dly_d       = dly_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = 8'h00;
        out_user_d  = 1'b0;
        dst_mac_d   = dst_mac_q;
        src_mac_d   = src_mac_q;
        ethertype_d = ethertype_q;
        hdr_valid_d = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;

        if (in_axis_tvalid) begin
            cnt_d = cnt_inc;
            crc_d = crc_nx;
            err_d = err_nx;
            case (state_q)
                ST_RESYNC: begin
                    if (in_axis_tlast) state_d = ST_HDR;
                end
                ST_HDR: begin
                    if (cnt_q < 11'd6) begin
                        dst_sh_d = dst_full;
                    end else if (cnt_q < 11'd12) begin
                        src_sh_d = {src_sh_q[39:0], in_axis_tdata};
                    end else begin
                        et_sh_d = {et_sh_q[7:0], in_axis_tdata};
                    end
                    if (cnt_q == 11'd5 && !accept_now) state_d = ST_DROP;
                    if (cnt_q == 11'd13) begin
                        hdr_valid_d = 1'b1;
                        dst_mac_d   = dst_sh_q;
                        src_mac_d   = src_sh_q;
                        ethertype_d = {et_sh_q[7:0], in_axis_tdata};
                        state_d     = ST_PAYLOAD;
                    end
                    // Bytes 6..13 are only seen here after acceptance at byte 5.
                    if (in_axis_tlast) begin
                        state_d     = ST_HDR;
                        frame_err_d = (cnt_q > 11'd5) || (cnt_q == 11'd5 && accept_now);
                    end
                end
                ST_PAYLOAD: begin
                    dly_d  = {dly_q[23:0], in_axis_tdata};
                    fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
                    if (fill_q == 3'd4) begin
                        out_valid_d = 1'b1;
                        out_data_d  = dly_q[31:24];
                        out_last_d  = in_axis_tlast;
                        out_user_d  = in_axis_tlast & err_nx;
                    end
                    if (in_axis_tlast) begin
                        state_d = ST_HDR;
                        if (fill_q == 3'd4) begin
                            frame_ok_d  = ~err_nx;
                            frame_err_d = err_nx;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (in_axis_tlast) state_d = ST_HDR;
                end
            endcase
            if (in_axis_tlast) begin
                cnt_d  = 11'd0;
                crc_d  = 32'hFFFFFFFF;
                err_d  = 1'b0;
                fill_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q     <= ST_RESYNC;
            cnt_q       <= 11'd0;
            crc_q       <= 32'hFFFFFFFF;
            err_q       <= 1'b0;
            dst_sh_q    <= 48'h0;
            src_sh_q    <= 48'h0;
            et_sh_q     <= 16'h0;
            dly_q       <= 32'h0;
            fill_q      <= 3'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 8'h00;
            out_user_q  <= 1'b0;
            dst_mac_q   <= 48'h0;
            src_mac_q   <= 48'h0;
            ethertype_q <= 16'h0;
            hdr_valid_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            dst_sh_q    <= dst_sh_d;
            src_sh_q    <= src_sh_d;
            et_sh_q     <= et_sh_d;
            dly_q       <= dly_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            dst_mac_q   <= dst_mac_d;
            src_mac_q   <= src_mac_d;
            ethertype_q <= ethertype_d;
            hdr_valid_q <= hdr_valid_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_axis_tvalid = out_valid_q;
    assign out_axis_tlast  = out_last_q;
    assign out_axis_tdata  = out_data_q;
    assign out_axis_tuser  = out_user_q;
    assign dst_mac         = dst_mac_q;
    assign src_mac         = src_mac_q;
    assign ethertype       = ethertype_q;
    assign hdr_valid       = hdr_valid_q;
    assign frame_ok        = frame_ok_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_eth_deframer.sv
// Bench for eth_deframer: a default build (a) and a promiscuous, FCS-ignoring
// build (b) share one input stream; each has its own expected queues.
module tb_eth_deframer;

    logic        clk = 1'b0;
    logic        sreset;
    logic [47:0] local_mac = 48'h000102030405;
    logic        in_valid, in_last, in_user;
    logic [7:0]  in_data;

    logic        a_ov, a_ol, a_ou, a_hv, a_ok, a_er;
    logic [7:0]  a_od;
    logic [47:0] a_dm, a_sm;
    logic [15:0] a_et;
    logic        b_ov, b_ol, b_ou, b_hv, b_ok, b_er;
    logic [7:0]  b_od;
    logic [47:0] b_dm, b_sm;
    logic [15:0] b_et;

    always #5 clk = ~clk;

    eth_deframer dut_a (
        .clk(clk), .sreset(sreset), .local_mac(local_mac),
        .in_axis_tvalid(in_valid), .in_axis_tlast(in_last),
        .in_axis_tdata(in_data), .in_axis_tuser(in_user),
        .out_axis_tvalid(a_ov), .out_axis_tlast(a_ol),
        .out_axis_tdata(a_od), .out_axis_tuser(a_ou),
        .dst_mac(a_dm), .src_mac(a_sm), .ethertype(a_et),
        .hdr_valid(a_hv), .frame_ok(a_ok), .frame_err(a_er)
    );

    eth_deframer #(.PROMISCUOUS(1'b1), .CHECK_FCS(1'b0)) dut_b (
        .clk(clk), .sreset(sreset), .local_mac(local_mac),
        .in_axis_tvalid(in_valid), .in_axis_tlast(in_last),
        .in_axis_tdata(in_data), .in_axis_tuser(in_user),
        .out_axis_tvalid(b_ov), .out_axis_tlast(b_ol),
        .out_axis_tdata(b_od), .out_axis_tuser(b_ou),
        .dst_mac(b_dm), .src_mac(b_sm), .ethertype(b_et),
        .hdr_valid(b_hv), .frame_ok(b_ok), .frame_err(b_er)
    );

    localparam logic [1:0] EV_HDR = 2'b11;
    localparam logic [1:0] EV_OK  = 2'b01;
    localparam logic [1:0] EV_ERR = 2'b10;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] fr [0:2047];
    logic       fr_tu [0:2047];
    int         fr_len;
    bit         fcs_bad;
    bit         gaps;

    logic [9:0]   beat_q0[$], beat_q1[$];
    logic [1:0]   ev_q0[$], ev_q1[$];
    logic [111:0] hdr_q0[$], hdr_q1[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int j = 0; j < 8; j++) begin
            fb = r[0] ^ b[j];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [47:0] src,
                         input logic [15:0] et, input int plen, input bit rnd);
        logic [31:0] c;
        fr_len = 18 + plen;
        for (int i = 0; i < 6; i++) begin
            fr[i]     = dst[47-8*i -: 8];
            fr[6 + i] = src[47-8*i -: 8];
        end
        fr[12] = et[15:8];
        fr[13] = et[7:0];
        for (int i = 0; i < plen; i++)
            fr[14 + i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 14 + plen; i++) c = crc_upd(c, fr[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) fr[14 + plen + k] = c[8*k +: 8];
        for (int i = 0; i < 2048; i++) fr_tu[i] = 1'b0;
        fcs_bad = 1'b0;
    endtask

    task automatic expect_one(input int d, input bit prom, input bit chkfcs);
        logic [47:0] dst;
        bit          acc, err, anytu, lst;
        dst = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
        acc = prom || (dst == local_mac) || (&dst);
        if (acc && fr_len >= 14) begin
            anytu = 1'b0;
            for (int i = 0; i < fr_len; i++) anytu = anytu | fr_tu[i];
            err = anytu || (chkfcs && fcs_bad) || fr_len < 64 || fr_len > 1518;
            if (d == 0) begin
                ev_q0.push_back(EV_HDR);
                hdr_q0.push_back({dst, fr[6], fr[7], fr[8], fr[9], fr[10], fr[11], fr[12], fr[13]});
            end else begin
                ev_q1.push_back(EV_HDR);
                hdr_q1.push_back({dst, fr[6], fr[7], fr[8], fr[9], fr[10], fr[11], fr[12], fr[13]});
            end
            for (int i = 14; i <= fr_len - 5; i++) begin
                lst = (i == fr_len - 5);
                if (d == 0) beat_q0.push_back({lst, lst & err, fr[i]});
                else        beat_q1.push_back({lst, lst & err, fr[i]});
            end
            if (d == 0) ev_q0.push_back(err ? EV_ERR : EV_OK);
            else        ev_q1.push_back(err ? EV_ERR : EV_OK);
        end
    endtask

    task automatic expect_frame();
        expect_one(0, 1'b0, 1'b1);
        expect_one(1, 1'b1, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, {a_ov, a_ol, a_od, a_ou, a_hv, a_ok, a_er, a_dm, a_sm, a_et}, 128'h0);
        chk({tag, "_b"}, {b_ov, b_ol, b_od, b_ou, b_hv, b_ok, b_er, b_dm, b_sm, b_et}, 128'h0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int rst_at);
        for (int i = 0; i < fr_len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle();
            in_valid = 1'b1;
            in_data  = fr[i];
            in_last  = (i == fr_len - 1);
            in_user  = fr_tu[i];
            sreset   = (i == rst_at);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_user  = 1'b0;
            sreset   = 1'b0;
            if (i == rst_at) check_zero("midreset_zero");
        end
    endtask

    task automatic mon(input int d, input logic ov, input logic ol, input logic ou,
                       input logic [7:0] od, input logic hv, input logic ok, input logic er,
                       input logic [47:0] dm, input logic [47:0] sm, input logic [15:0] et);
        string        nm;
        int           sz;
        logic [9:0]   eb;
        logic [1:0]   ee;
        logic [111:0] eh;
        nm = (d == 0) ? "a" : "b";
        if (ov) begin
            sz = (d == 0) ? beat_q0.size() : beat_q1.size();
            chk({nm, "_beat_expected"}, sz > 0, 1);
            if (sz > 0) begin
                eb = (d == 0) ? beat_q0.pop_front() : beat_q1.pop_front();
                chk({nm, "_beat"}, {ol, ou, od}, eb);
            end
            if (ol) chk({nm, "_end_pulse"}, {ok, er}, {~ou, ou});
        end
        if (hv) begin
            sz = (d == 0) ? ev_q0.size() : ev_q1.size();
            chk({nm, "_hdr_expected"}, sz > 0, 1);
            if (sz > 0) begin
                ee = (d == 0) ? ev_q0.pop_front() : ev_q1.pop_front();
                eh = (d == 0) ? hdr_q0.pop_front() : hdr_q1.pop_front();
                chk({nm, "_hdr_event"}, EV_HDR, ee);
                chk({nm, "_hdr_fields"}, {dm, sm, et}, eh);
            end
        end
        if (ok || er) begin
            sz = (d == 0) ? ev_q0.size() : ev_q1.size();
            chk({nm, "_end_expected"}, sz > 0, 1);
            if (sz > 0) begin
                ee = (d == 0) ? ev_q0.pop_front() : ev_q1.pop_front();
                chk({nm, "_end_event"}, {er, ok}, ee);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_ov, a_ol, a_ou, a_od, a_hv, a_ok, a_er, a_dm, a_sm, a_et);
        mon(1, b_ov, b_ol, b_ou, b_od, b_hv, b_ok, b_er, b_dm, b_sm, b_et);
    end

    initial begin
        sreset   = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
        in_data  = 8'h00;
        gaps     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_zero");
        sreset = 1'b0;
        idle();

        // Frame in flight at reset release: swallowed by resync.
        build(local_mac, 48'h111111111111, 16'h0800, 46, 1'b1);
        send_frame(-1);

        // Broadcast, minimum legal length, good FCS.
        build(48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5, 46, 1'b0);
        expect_frame();
        send_frame(-1);

        // Payload byte 10 corrupted after FCS was computed.
        build(48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5, 46, 1'b0);
        fr[24]  = 8'hFF;
        fcs_bad = 1'b1;
        expect_frame();
        send_frame(-1);

        // Foreign unicast: dropped by a, passed by promiscuous b.
        build(48'h0A0B0C0D0E0F, 48'h000102030405, 16'h88B5, 46, 1'b0);
        expect_frame();
        send_frame(-1);

        // Unicast to the station address.
        build(local_mac, 48'hA1A2A3A4A5A6, 16'h0806, 100, 1'b1);
        expect_frame();
        send_frame(-1);

        // 16-byte runt: header accepted, nothing emitted.
        build(48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5, 2, 1'b0);
        fr_len  = 16;
        fcs_bad = 1'b1;
        expect_frame();
        send_frame(-1);

        // 60 and 63 bytes with good FCS: runts by length.
        build(48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5, 42, 1'b0);
        expect_frame();
        send_frame(-1);
        build(48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5, 45, 1'b1);
        expect_frame();
        send_frame(-1);

        // PHY error on byte 30 of a valid 64-byte frame.
        build(48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5, 46, 1'b0);
        fr_tu[30] = 1'b1;
        expect_frame();
        send_frame(-1);

        // Longest legal frame, then one byte over.
        build(local_mac, 48'h000102030405, 16'h0800, 1500, 1'b1);
        expect_frame();
        send_frame(-1);
        build(local_mac, 48'h000102030405, 16'h0800, 1501, 1'b1);
        expect_frame();
        send_frame(-1);

        // Random input gaps across back-to-back frames.
        gaps = 1'b1;
        for (int k = 0; k < 4; k++) begin
            build(48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5, $urandom_range(46, 80), 1'b1);
            if (k == 2) begin
                fr[20]  = ~fr[20];
                fcs_bad = 1'b1;
            end
            expect_frame();
            send_frame(-1);
        end
        gaps = 1'b0;

        // Reset on byte 20: two payload beats already emitted, rest discarded.
        build(48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5, 46, 1'b0);
        ev_q0.push_back(EV_HDR);
        ev_q1.push_back(EV_HDR);
        hdr_q0.push_back({48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5});
        hdr_q1.push_back({48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5});
        beat_q0.push_back({2'b00, fr[14]});
        beat_q0.push_back({2'b00, fr[15]});
        beat_q1.push_back({2'b00, fr[14]});
        beat_q1.push_back({2'b00, fr[15]});
        send_frame(20);
        build(48'hFFFFFFFFFFFF, 48'h000102030405, 16'h88B5, 50, 1'b1);
        expect_frame();
        send_frame(-1);

        repeat (20) idle();
        chk("a_beats_left", beat_q0.size(), 0);
        chk("b_beats_left", beat_q1.size(), 0);
        chk("a_events_left", ev_q0.size(), 0);
        chk("b_events_left", ev_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
